// File: rtl/seg7_s2p_rx.sv
`default_nettype none
// ============================================================================
// seg7_s2p_rx : 7-seg serial link receiver, oversampled in the clk domain.
// Optional hex decode via SEG7_RX_DECODE_EN.  Rev 1.0
// ============================================================================
module seg7_s2p_rx #(
  parameter int DATA_BITS       = 64,
  parameter int DATA_COUNT_BITS = 6,
  parameter int DIR             = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_clk,
  input  logic                   s_clrn,
  input  logic                   sout,
  input  logic                   en,
  output logic [DATA_BITS-1:0]   pdata,
  output logic                   pdata_valid,
  output logic                   frame_err,
  output logic                   busy,
`ifdef SEG7_RX_DECODE_EN
  output logic [DATA_BITS/2-1:0] hex_out,
  output logic [DATA_BITS/8-1:0] hex_bad,
`endif
  output logic [15:0]            frame_cnt
);

  localparam logic [DATA_COUNT_BITS-1:0] c_LAST = DATA_COUNT_BITS'(DATA_BITS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  logic r_sclk_s1, r_sclk_s2, r_sclk_h;
  logic r_clrn_s1, r_clrn_s2, r_clrn_h;
  logic r_sout_s1, r_sout_s2, r_sout_h;
  logic r_en_s1, r_en_s2, r_en_h;
  logic r_rise;

  state_t                     r_state, w_state_nxt;
  logic [DATA_BITS-1:0]       r_sr, w_sr_nxt, w_sr_shift;
  logic [DATA_COUNT_BITS-1:0] r_cnt, w_cnt_nxt;
  logic                       w_clr, w_accept, w_done, w_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {r_sclk_s1, r_sclk_s2, r_sclk_h} <= '0;
      {r_clrn_s1, r_clrn_s2, r_clrn_h} <= '0;
      {r_sout_s1, r_sout_s2, r_sout_h} <= '0;
      {r_en_s1, r_en_s2, r_en_h}       <= '0;
      r_rise                           <= 1'b0;
    end else begin
      {r_sclk_s1, r_sclk_s2, r_sclk_h} <= {s_clk, r_sclk_s1, r_sclk_s2};
      {r_clrn_s1, r_clrn_s2, r_clrn_h} <= {s_clrn, r_clrn_s1, r_clrn_s2};
      {r_sout_s1, r_sout_s2, r_sout_h} <= {sout, r_sout_s1, r_sout_s2};
      {r_en_s1, r_en_s2, r_en_h}       <= {en, r_en_s1, r_en_s2};
      r_rise                           <= r_sclk_s2 & ~r_sclk_h;
    end
  end

  // History flops hold sout/en as they were when the edge was detected,
  // so they line up with the registered rise flag.
  assign w_clr    = ~r_clrn_s2 | ~r_clrn_h;
  assign w_accept = r_rise & r_en_h;

  generate
    if (DIR == 0) begin : g_msb_first
      assign w_sr_shift = {r_sr[DATA_BITS-2:0], r_sout_h};
    end else begin : g_lsb_first
      assign w_sr_shift = {r_sout_h, r_sr[DATA_BITS-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    w_err       = 1'b0;
    if (w_clr) begin
      w_sr_nxt    = '0;
      w_cnt_nxt   = '0;
      w_state_nxt = IDLE;
    end else if (w_accept && r_cnt == c_LAST) begin
      w_done      = 1'b1;
      w_sr_nxt    = w_sr_shift;
      w_cnt_nxt   = '0;
      w_state_nxt = IDLE;
    end else if (r_state == SHIFT && !r_en_s2) begin
      w_err       = 1'b1;
      w_sr_nxt    = '0;
      w_cnt_nxt   = '0;
      w_state_nxt = IDLE;
    end else if (w_accept) begin
      w_sr_nxt    = w_sr_shift;
      w_cnt_nxt   = r_cnt + DATA_COUNT_BITS'(1);
      w_state_nxt = SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr        <= '0;
      r_cnt       <= '0;
      pdata       <= '0;
      pdata_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      r_sr        <= w_sr_nxt;
      r_cnt       <= w_cnt_nxt;
      pdata_valid <= w_done;
      frame_err   <= w_err;
      if (w_done) begin
        pdata <= w_sr_shift;
        if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign busy = (r_state == SHIFT);

`ifdef SEG7_RX_DECODE_EN
  // Returns {bad, nibble}; dp (bit 7) is not part of the match.
  function automatic logic [4:0] f_decode(input logic [6:0] seg);
    case (seg)
      7'h40: f_decode = 5'h00;  7'h79: f_decode = 5'h01;
      7'h24: f_decode = 5'h02;  7'h30: f_decode = 5'h03;
      7'h19: f_decode = 5'h04;  7'h12: f_decode = 5'h05;
      7'h02: f_decode = 5'h06;  7'h78: f_decode = 5'h07;
      7'h00: f_decode = 5'h08;  7'h10: f_decode = 5'h09;
      7'h08: f_decode = 5'h0A;  7'h03: f_decode = 5'h0B;
      7'h46: f_decode = 5'h0C;  7'h21: f_decode = 5'h0D;
      7'h06: f_decode = 5'h0E;  7'h0E: f_decode = 5'h0F;
      default: f_decode = 5'h10;
    endcase
  endfunction

  generate
    for (genvar gi = 0; gi < DATA_BITS / 8; gi++) begin : g_dec
      logic [4:0] w_dec;
      assign w_dec = f_decode(w_sr_shift[8*gi +: 7]);
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          hex_out[4*gi +: 4] <= '0;
          hex_bad[gi]        <= 1'b0;
        end else if (w_done) begin
          hex_out[4*gi +: 4] <= w_dec[3:0];
          hex_bad[gi]        <= w_dec[4];
        end
      end
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg7_s2p_rx.sv
`default_nettype none
// Scoreboarded bench: two receivers (MSB-first and LSB-first) share one link.
module tb_seg7_s2p_rx;

  logic clk = 1'b0;
  logic rst, s_clk, s_clrn, sout, en;
  logic [63:0] pdata0, pdata1;
  logic        valid0, valid1, ferr0, ferr1, busy0, busy1;
  logic [15:0] fcnt0, fcnt1;
`ifdef SEG7_RX_DECODE_EN
  logic [31:0] hex0, hex1;
  logic [7:0]  hbad0, hbad1;
`endif

  always #5 clk = ~clk;

  seg7_s2p_rx #(.DATA_BITS(64), .DATA_COUNT_BITS(6), .DIR(0)) u_dut0 (
    .clk(clk), .rst(rst), .s_clk(s_clk), .s_clrn(s_clrn), .sout(sout), .en(en),
    .pdata(pdata0), .pdata_valid(valid0), .frame_err(ferr0), .busy(busy0),
`ifdef SEG7_RX_DECODE_EN
    .hex_out(hex0), .hex_bad(hbad0),
`endif
    .frame_cnt(fcnt0));

  seg7_s2p_rx #(.DATA_BITS(64), .DATA_COUNT_BITS(6), .DIR(1)) u_dut1 (
    .clk(clk), .rst(rst), .s_clk(s_clk), .s_clrn(s_clrn), .sout(sout), .en(en),
    .pdata(pdata1), .pdata_valid(valid1), .frame_err(ferr1), .busy(busy1),
`ifdef SEG7_RX_DECODE_EN
    .hex_out(hex1), .hex_bad(hbad1),
`endif
    .frame_cnt(fcnt1));

  int total = 0;
  int bad   = 0;
  int nerr0 = 0, nerr1 = 0, exp_err = 0;
  int exp_cnt = 0;
  logic [63:0] qd0[$], qd1[$];
  int          qc0[$], qc1[$];
  logic [63:0] last0 = '0, last1 = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rev64(input logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = w[63-i];
    return r;
  endfunction

`ifdef SEG7_RX_DECODE_EN
  // Model: search the digit table; unmatched byte -> nibble 0, bad bit set.
  function automatic logic [39:0] model_decode(input logic [63:0] w);
    logic [7:0]  codes [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [31:0] h = '0;
    logic [7:0]  b = '0;
    for (int k = 0; k < 8; k++) begin
      b[k] = 1'b1;
      for (int d = 0; d < 16; d++)
        if (w[8*k +: 7] == codes[d][6:0]) begin
          h[4*k +: 4] = 4'(d);
          b[k] = 1'b0;
        end
    end
    return {b, h};
  endfunction
`endif

  always @(negedge clk) begin
    if (rst && valid0) begin
      if (qd0.size() == 0) chk("unexpected_valid0", 64'd1, 64'd0);
      else begin
        logic [63:0] e;
        int ec;
        e  = qd0.pop_front();
        ec = qc0.pop_front();
        chk("pdata0", pdata0, e);
        chk("frame_cnt0", 64'(fcnt0), 64'(ec));
`ifdef SEG7_RX_DECODE_EN
        chk("hex_out0", 64'(hex0), 64'(model_decode(e) & 40'hFFFFFFFF));
        chk("hex_bad0", 64'(hbad0), 64'(model_decode(e) >> 32));
`endif
      end
    end
    if (rst && valid1) begin
      if (qd1.size() == 0) chk("unexpected_valid1", 64'd1, 64'd0);
      else begin
        logic [63:0] e;
        int ec;
        e  = qd1.pop_front();
        ec = qc1.pop_front();
        chk("pdata1", pdata1, e);
        chk("frame_cnt1", 64'(fcnt1), 64'(ec));
      end
    end
    if (rst && ferr0) nerr0++;
    if (rst && ferr1) nerr1++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sout = b;
    wait_clk(4);
    s_clk = 1'b1;
    wait_clk(4);
    s_clk = 1'b0;
  endtask

  // Bits go out word[63] first; DIR=0 sees the word, DIR=1 its bit reverse.
  task automatic send_frame(input logic [63:0] w);
    exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 1;
    qd0.push_back(w);
    qd1.push_back(rev64(w));
    qc0.push_back(exp_cnt);
    qc1.push_back(exp_cnt);
    last0 = w;
    last1 = rev64(w);
    en = 1'b1;
    wait_clk(4);
    for (int i = 63; i >= 0; i--) send_bit(w[i]);
    wait_clk(12);
  endtask

  task automatic send_partial(input int n);
    en = 1'b1;
    wait_clk(4);
    for (int i = 0; i < n; i++) send_bit(1'($urandom));
  endtask

  initial begin
    rst = 1'b0; s_clk = 1'b0; s_clrn = 1'b1; sout = 1'b0; en = 1'b0;
    wait_clk(5);
    chk("rst_pdata", pdata0, 64'd0);
    chk("rst_valid", 64'(valid0 | valid1), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_fcnt", 64'(fcnt0), 64'd0);
    rst = 1'b1;
    wait_clk(5);

    send_frame(64'h0123456789ABCDEF);
    chk("busy_after_frame", 64'(busy0), 64'd0);
    chk("pdata0_hold", pdata0, 64'h0123456789ABCDEF);
    send_frame(rev64(64'h0123456789ABCDEF));
    send_frame(rev64(64'hFFFF0000AAAA5555));
    chk("pdata1_second", pdata1, 64'hFFFF0000AAAA5555);

    // Truncated frame: 10 bits then en drops.
    send_partial(10);
    chk("busy_mid_frame", 64'(busy0), 64'd1);
    en = 1'b0;
    exp_err++;
    wait_clk(12);
    chk("err_count0", 64'(nerr0), 64'(exp_err));
    chk("pdata0_kept", pdata0, last0);
    chk("pdata1_kept", pdata1, last1);
    chk("fcnt_kept", 64'(fcnt0), 64'(exp_cnt));
    send_frame({$urandom, $urandom});

    // Link clear mid-frame.
    send_partial(30);
    s_clrn = 1'b0;
    wait_clk(4);
    s_clrn = 1'b1;
    wait_clk(6);
    chk("busy_after_clrn", 64'(busy0), 64'd0);
    send_frame({$urandom, $urandom});

    // Reset mid-frame.
    send_partial(40);
    rst = 1'b0;
    #1;
    chk("midrst_pdata0", pdata0, 64'd0);
    chk("midrst_pdata1", pdata1, 64'd0);
    chk("midrst_fcnt", 64'(fcnt0), 64'd0);
    chk("midrst_busy", 64'(busy0 | busy1), 64'd0);
    exp_cnt = 0;
    last0 = '0;
    last1 = '0;
    en = 1'b0;
    wait_clk(3);
    rst = 1'b1;
    wait_clk(5);
    send_frame({$urandom, $urandom});
    chk("fcnt_after_rst", 64'(fcnt1), 64'd1);

    // Back-to-back random frames with en held high.
    for (int k = 0; k < 4; k++) send_frame({$urandom, $urandom});

`ifdef SEG7_RX_DECODE_EN
    send_frame(64'hC0F9A4B09992828E);
    chk("hex_digits", 64'(hex0), 64'h0123456F);
    chk("hex_bad_none", 64'(hbad0), 64'd0);
    send_frame(64'hC0F9A4B0999282FF);
    chk("hex_digits_bad", 64'(hex0), 64'h01234560);
    chk("hex_bad_low", 64'(hbad0), 64'd1);
`endif

    for (int i = 0; i < 100 && (qd0.size() != 0 || qd1.size() != 0); i++) wait_clk(1);
    chk("queue0_drained", 64'(qd0.size()), 64'd0);
    chk("queue1_drained", 64'(qd1.size()), 64'd0);
    chk("err_total0", 64'(nerr0), 64'(exp_err));
    chk("err_total1", 64'(nerr1), 64'(exp_err));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
